// File: rtl/muldiv_if.sv
// Start/done handshake between the control unit (master) and the MULT/DIV unit (slave).
interface muldiv_if #(parameter int WIDTH = 16);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (output start, op, a, b,
                    input  busy, done, hi, lo, div_by_zero);
    modport slave  (input  start, op, a, b,
                    output busy, done, hi, lo, div_by_zero);
endinterface

// File: rtl/muldiv_seq.sv
// Sequential unsigned 16x16 multiply / 16/16 divide built on one twos_comp adder.
// Optional MULDIV_ZERO_BYPASS_EN: zero operands skip the iteration loop.
module twos_comp #(parameter int WIDTH = 16) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             addsub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] yi;

    assign yi   = y ^ {WIDTH{addsub}};
    assign c[0] = cin ^ addsub;
    for (genvar i = 0; i < WIDTH; i++) begin : gen_fa
        assign sum[i]   = x[i] ^ yi[i] ^ c[i];
        assign c[i+1]   = (x[i] & yi[i]) | (c[i] & (x[i] ^ yi[i]));
    end
    assign cout     = c[WIDTH];
    assign overflow = c[WIDTH] ^ c[WIDTH-1];
endmodule

module muldiv_seq #(parameter int WIDTH = 16) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, nstate;
    logic             op_r;
    logic [WIDTH-1:0] wh, wl, opnd;      // acc_hi/rem, acc_lo/quo, mcand/divisor
    logic [WIDTH-1:0] nwh, nwl;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             dz_q;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] x_in, sum;
    logic             cout, ovf_unused;
    logic             dbz_req, zbyp;

    assign dbz_req = bus.op && (bus.b == '0);
`ifdef MULDIV_ZERO_BYPASS_EN
    assign zbyp = bus.op ? ((bus.a == '0) && (bus.b != '0))
                         : ((bus.a == '0) || (bus.b == '0));
`else
    assign zbyp = 1'b0;
`endif

    // Divide subtracts from the low 16 bits of {rem, quo[15]}; multiply adds into acc_hi.
    assign x_in = op_r ? {wh[WIDTH-2:0], wl[WIDTH-1]} : wh;

    twos_comp #(.WIDTH(WIDTH)) u_add (
        .x(x_in), .y(opnd), .cin(1'b0), .addsub(op_r),
        .sum(sum), .cout(cout), .overflow(ovf_unused)
    );

    always_comb begin
        nwh = wh;
        nwl = wl;
        if (!op_r) begin
            if (wl[0]) begin
                nwh = {cout, sum[WIDTH-1:1]};
                nwl = {sum[0], wl[WIDTH-1:1]};
            end else begin
                nwh = {1'b0, wh[WIDTH-1:1]};
                nwl = {wh[0], wl[WIDTH-1:1]};
            end
        end else begin
            // Bit 16 of the partial remainder set means it certainly exceeds the divisor.
            if (wh[WIDTH-1] | cout) begin
                nwh = sum;
                nwl = {wl[WIDTH-2:0], 1'b1};
            end else begin
                nwh = x_in;
                nwl = {wl[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (bus.start) nstate = (dbz_req || zbyp) ? DONE : CALC;
            CALC:    if (cnt == 4'hF) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 1'b0;
            wh   <= '0;
            wl   <= '0;
            opnd <= '0;
            cnt  <= '0;
            hi_q <= '0;
            lo_q <= '0;
            dz_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_r <= bus.op;
                    opnd <= bus.op ? bus.b : bus.a;
                    wh   <= '0;
                    wl   <= bus.op ? bus.a : bus.b;
                    cnt  <= '0;
                    dz_q <= 1'b0;
                    if (dbz_req) begin
                        hi_q <= bus.a;
                        lo_q <= '1;
                        dz_q <= 1'b1;
                    end else if (zbyp) begin
                        hi_q <= '0;
                        lo_q <= '0;
                    end
                end
                CALC: begin
                    wh  <= nwh;
                    wl  <= nwl;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'hF) begin
                        hi_q <= nwh;
                        lo_q <= nwl;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dz_q;
endmodule
